// File: rtl/tcdm_bank_sched.sv
// Round-robin scheduler and zero-fill sequencer in front of one TCDM bank.
// Optional contention counters are built when TCDM_SCHED_STATS_EN is defined.
module tcdm_bank_sched #(
    parameter int BANK_SIZE  = 256,
    parameter int NB_REQ     = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = $clog2(BANK_SIZE)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           init_start_i,
    output logic                           init_busy_o,
    output logic                           init_done_o,
    input  logic [NB_REQ-1:0]              req_i,
    input  logic [NB_REQ*ADDR_WIDTH-1:0]   add_i,
    input  logic [NB_REQ-1:0]              wen_i,
    input  logic [NB_REQ*DATA_WIDTH-1:0]   wdata_i,
    input  logic [NB_REQ*DATA_WIDTH/8-1:0] be_i,
    output logic [NB_REQ-1:0]              gnt_o,
    output logic [NB_REQ-1:0]              r_valid_o,
    output logic [DATA_WIDTH-1:0]          r_rdata_o,
    output logic                           bank_req_o,
    output logic                           bank_wen_o,
    output logic [ADDR_WIDTH-1:0]          bank_add_o,
    output logic [DATA_WIDTH-1:0]          bank_wdata_o,
    output logic [DATA_WIDTH/8-1:0]        bank_be_o,
    input  logic                           bank_gnt_i,
    input  logic [DATA_WIDTH-1:0]          bank_rdata_i,
    output logic [NB_REQ*16-1:0]           stall_cnt_o,
    input  logic                           stall_clr_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W    = $clog2(NB_REQ);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BANK_SIZE - 1);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_INIT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PTR_W-1:0]      r_rr_ptr;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic                  r_init_done;
    logic [NB_REQ-1:0]     r_rvalid;
    logic                  r_resp_rd;

    logic [PTR_W-1:0]      w_win;
    logic [PTR_W-1:0]      w_idx;
    logic [PTR_W-1:0]      w_rr_nxt;
    logic                  w_any;
    logic                  w_init_last;

    // Search from the pointer upward; descending loop lets the nearest hit win.
    always_comb begin
        w_win = '0;
        w_idx = '0;
        w_any = 1'b0;
        for (int i = NB_REQ - 1; i >= 0; i--) begin
            w_idx = PTR_W'((int'(r_rr_ptr) + i) % NB_REQ);
            if (req_i[w_idx]) begin
                w_win = w_idx;
                w_any = 1'b1;
            end
        end
    end

    assign w_rr_nxt    = PTR_W'((int'(w_win) + 1) % NB_REQ);
    assign w_init_last = (r_state == ST_INIT) && bank_gnt_i
                         && (r_init_cnt == LAST_ADDR);

    always_comb begin
        w_state_nxt  = r_state;
        bank_req_o   = 1'b0;
        bank_wen_o   = 1'b1;
        bank_add_o   = '0;
        bank_wdata_o = '0;
        bank_be_o    = '0;
        gnt_o        = '0;
        unique case (r_state)
            ST_ARB: begin
                if (init_start_i) begin
                    w_state_nxt = ST_INIT;
                end else begin
                    bank_req_o   = w_any;
                    bank_wen_o   = wen_i[w_win];
                    bank_add_o   = add_i[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
                    bank_wdata_o = wdata_i[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
                    bank_be_o    = be_i[int'(w_win)*BE_WIDTH +: BE_WIDTH];
                    if (w_any) gnt_o[w_win] = bank_gnt_i;
                end
            end
            ST_INIT: begin
                bank_req_o   = 1'b1;
                bank_wen_o   = 1'b0;
                bank_add_o   = r_init_cnt;
                bank_wdata_o = '0;
                bank_be_o    = '1;
                if (w_init_last) w_state_nxt = ST_ARB;
            end
            default: w_state_nxt = ST_ARB;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_ARB;
            r_rr_ptr    <= '0;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
            r_rvalid    <= '0;
            r_resp_rd   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_done <= w_init_last;
            r_rvalid    <= gnt_o;
            r_resp_rd   <= (|gnt_o) & wen_i[w_win];
            if (|gnt_o) r_rr_ptr <= w_rr_nxt;
            if ((r_state == ST_INIT) && bank_gnt_i) begin
                r_init_cnt <= w_init_last ? '0 : r_init_cnt + 1'b1;
            end
        end
    end

    assign init_busy_o = (r_state == ST_INIT);
    assign init_done_o = r_init_done;
    assign r_valid_o   = r_rvalid;
    // Write responses carry zero data; the bank drives rdata only after reads.
    assign r_rdata_o   = r_resp_rd ? bank_rdata_i : '0;

`ifdef TCDM_SCHED_STATS_EN
    logic [15:0] r_stall_cnt [NB_REQ];

    always_ff @(posedge clk_i) begin
        if (rst_i || stall_clr_i) begin
            for (int k = 0; k < NB_REQ; k++) r_stall_cnt[k] <= '0;
        end else if (r_state == ST_ARB) begin
            for (int k = 0; k < NB_REQ; k++) begin
                if (req_i[k] && !gnt_o[k] && (r_stall_cnt[k] != 16'hFFFF)) begin
                    r_stall_cnt[k] <= r_stall_cnt[k] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        stall_cnt_o = '0;
        for (int k = 0; k < NB_REQ; k++) stall_cnt_o[k*16 +: 16] = r_stall_cnt[k];
    end
`else
    logic w_unused_stall_clr;
    assign w_unused_stall_clr = stall_clr_i;
    assign stall_cnt_o        = '0;
`endif

endmodule

// File: doc/tcdm_bank_sched.md
Name: tcdm_bank_sched

Overview:
Per-bank scheduler that sits in front of one TCDM SRAM bank (tc_sram or ecc_sram_wrap slave) and shares it between NB_REQ requesters with round-robin arbitration. It also sequences a zero-fill initialisation of the whole bank on command. It returns a one-cycle-latency response to the granted requester, and honours the bank's grant, which is always 1 for plain SRAM and may stall for ECC banks.

Parameters:
BANK_SIZE, 256, words per bank; power of two, >= 2
NB_REQ, 2, number of requesters; >= 2
DATA_WIDTH, 32, word width; be width = DATA_WIDTH/8
ADDR_WIDTH, $clog2(BANK_SIZE), bank word-address width (derived)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
init_start_i  in  1  start zero-fill of the bank
init_busy_o  out  1  zero-fill in progress
init_done_o  out  1  one-cycle pulse when zero-fill completes
req_i  in  NB_REQ  per-requester request
add_i  in  NB_REQ*ADDR_WIDTH  per-requester word address
wen_i  in  NB_REQ  per-requester write enable, active-low (0 = write)
wdata_i  in  NB_REQ*DATA_WIDTH  per-requester write data
be_i  in  NB_REQ*DATA_WIDTH/8  per-requester byte enables
gnt_o  out  NB_REQ  per-requester grant (combinational)
r_valid_o  out  NB_REQ  per-requester response valid
r_rdata_o  out  DATA_WIDTH  shared response data
bank_req_o, bank_wen_o, bank_add_o, bank_wdata_o, bank_be_o  out  1/1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  bank request side
bank_gnt_i  in  1  bank grant
bank_rdata_i  in  DATA_WIDTH  bank read data, valid 1 cycle after accepted read
stall_cnt_o  out  NB_REQ*16  per-requester contention counters (see Optional Feature)
stall_clr_i  in  1  clear contention counters

Behaviour:
- FSM states: ARB and INIT. Reset enters ARB.
- Reset values: init_busy_o=0, init_done_o=0, r_valid_o=0, r_rdata_o=0, RR pointer=0, init address counter=0, stall counters=0.
- ARB state, arbitration:
  - Winner is the first requester with req_i=1, searching from the RR pointer upward and wrapping NB_REQ-1 -> 0.
  - bank_* outputs mirror the winner's signals. bank_req_o=1 if any req_i=1.
  - gnt_o[winner] = bank_gnt_i. All other gnt_o bits are 0.
- RR pointer update: loads winner+1 (mod NB_REQ) only in a cycle where gnt_o is nonzero. It holds while bank_gnt_i=0, so the same winner is kept.
- Response path:
  - For every granted transaction, r_valid_o[winner]=1 exactly one cycle later, for both reads and writes.
  - r_rdata_o = bank_rdata_i for reads and 0 for writes.
  - Back-to-back grants give back-to-back responses.
- ARB -> INIT: init_start_i=1 in ARB.
  - That cycle: no grant, bank_req_o=0.
  - A response owed from the previous cycle's grant is still delivered.
  - Next state is INIT.
- INIT state:
  - bank_req_o=1, bank_wen_o=0, bank_be_o=all ones, bank_wdata_o=0, bank_add_o=counter.
  - All gnt_o=0. init_busy_o=1.
  - Counter increments only when bank_gnt_i=1.
  - When counter=BANK_SIZE-1 is accepted: counter wraps to 0, next state is ARB, init_done_o=1 for one cycle (the first ARB cycle).
  - init_start_i is ignored while in INIT.
  - No r_valid_o is produced for init writes.
- init_start_i and req_i in the same ARB cycle: init wins and no requester is granted.
- Reset mid-INIT: abort immediately to ARB, counter=0, no init_done_o pulse. Bank contents are undefined.
- Reset with a response pending: the response is dropped and r_valid_o=0.
- Requester protocol: a requester holds req_i and its payload stable until granted. The scheduler does not register request payloads.

Optional Feature:
Macro TCDM_SCHED_STATS_EN.
- Defined:
  - stall_cnt_o[k] increments by 1 in each ARB-state cycle where req_i[k]=1 and gnt_o[k]=0 (lost arbitration or bank stall). INIT cycles are not counted.
  - Counters are 16-bit and saturate at 0xFFFF.
  - stall_clr_i=1 zeroes all counters and takes precedence over an increment in the same cycle.
- Not defined: stall_cnt_o is tied to 0, stall_clr_i is ignored, and no counter flops exist.

Test Plan:
- Reset, then req_i=2'b11 for 4 cycles, bank_gnt_i=1 -> gnt_o sequence 01,10,01,10; r_valid_o follows one cycle later with the same pattern.
- Req 0 reads add 5 after a write of 0xDEADBEEF with be=4'hF to add 5 -> r_rdata_o=0xDEADBEEF, r_valid_o[0]=1 one cycle after the read grant.
- Pulse init_start_i, BANK_SIZE=256, bank_gnt_i=1 -> init_busy_o high for 256 cycles, init_done_o pulses once, gnt_o=0 throughout, then a read of any address returns 0.
- bank_gnt_i=0 for 3 cycles with req_i=2'b11, RR pointer=1 -> gnt_o=0, bank_add_o stays req 1's address; when bank_gnt_i=1, gnt_o=10 and req 0 is served next.
- Assert rst_i at init counter 100 -> init_busy_o=0 the next cycle, no init_done_o pulse, RR pointer=0.
- With TCDM_SCHED_STATS_EN defined: req_i=2'b11 for 10 cycles -> stall_cnt_o = 5 per requester; stall_clr_i pulse -> both 0. With stall_cnt_o[0] forced to 0xFFFF, a further losing cycle keeps it at 0xFFFF.
